// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, widths and sign helper for the restoring divider
package div_pkg;
    localparam int DIV_DATA_W = 8;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W + 1);
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} div_state_e;
    function automatic logic [DIV_DATA_W-1:0] neg_if(input logic [DIV_DATA_W-1:0] v, input logic c);
        return c ? -v : v;
    endfunction
endpackage

// File: rtl/div_01bit_restoring_step.sv
// div_01bit_restoring_step: one combinational restoring iteration
// ports: rem/din/dvs = partial remainder, next dividend bit, divisor; rem_n/q = new remainder, quotient bit
module div_01bit_restoring_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem,
    input  logic         din,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_n,
    output logic         q
);
    logic [W:0] t;
    assign t = {rem, din};
    assign q = t >= {1'b0, dvs};
    // both branches fit in W bits: a kept t is below dvs, a subtracted t leaves less than dvs
    assign rem_n = W'(q ? t - {1'b0, dvs} : t);
endmodule

// File: rtl/div_08bit_restoring.sv
// div_08bit_restoring: sequential signed/unsigned restoring divider with valid/ready handshakes
// ports: i_clk/i_rst_n clock and async active-low reset; i_valid/o_ready/i_signed/i_num_a/i_num_b request;
//        o_valid/i_ready/o_quo/o_rem/o_div_zero result; o_busy high while calculating or holding a result
module div_08bit_restoring
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_num_a,
    input  logic [DATA_W-1:0] i_num_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_quo,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_div_zero,
    output logic              o_busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    div_state_e state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem, dvd, dvs, step_rem, quo_fin;
    logic              step_q, neg_q, neg_r, a_neg, b_neg, accept, last;
    assign a_neg   = i_signed & i_num_a[DATA_W-1];
    assign b_neg   = i_signed & i_num_b[DATA_W-1];
    assign o_ready = i_rst_n && state == ST_IDLE;
    assign o_busy  = state != ST_IDLE;
    assign accept  = i_valid && o_ready;
    assign last    = state == ST_CALC && cnt == CNT_W'(1);
    // quotient bits shift into the vacated low end of the dividend register
    assign quo_fin = {dvd[DATA_W-2:0], step_q};
    div_01bit_restoring_step #(.W(DATA_W)) u_step (
        .rem   (rem),
        .din   (dvd[DATA_W-1]),
        .dvs   (dvs),
        .rem_n (step_rem),
        .q     (step_q)
    );
    always_comb begin
        state_n = state;
        if (accept)
            state_n = (i_num_b == '0) ? ST_DONE : ST_CALC;
        else if (last)
            state_n = ST_DONE;
        else if (state == ST_DONE && o_valid && i_ready)
            state_n = ST_IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_quo      <= '0;
            o_rem      <= '0;
            o_div_zero <= 1'b0;
            cnt        <= '0;
            rem        <= '0;
            dvd        <= '0;
            dvs        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            // result is announced one cycle after entering DONE and dropped on handshake
            o_valid <= state == ST_DONE && state_n == ST_DONE;
            if (accept) begin
                neg_q      <= a_neg ^ b_neg;
                neg_r      <= a_neg;
                dvd        <= neg_if(i_num_a, a_neg);
                dvs        <= neg_if(i_num_b, b_neg);
                rem        <= '0;
                cnt        <= CNT_W'(DATA_W);
                o_div_zero <= i_num_b == '0;
                if (i_num_b == '0) begin
                    o_quo <= '1;
                    o_rem <= i_num_a;
                end
            end else if (state == ST_CALC) begin
                rem <= step_rem;
                dvd <= quo_fin;
                cnt <= cnt - CNT_W'(1);
                if (last) begin
                    o_quo <= neg_if(quo_fin, neg_q);
                    o_rem <= neg_if(step_rem, neg_r);
                end
            end
        end
    end
endmodule

// File: tb/tb_div_08bit_restoring.sv
// tb_div_08bit_restoring: directed scoreboard bench for the restoring divider
module tb_div_08bit_restoring;
    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_signed = 1'b0;
    logic [7:0] i_num_a = '0;
    logic [7:0] i_num_b = '0;
    logic       i_ready = 1'b0;
    logic       o_ready, o_valid, o_div_zero, o_busy;
    logic [7:0] o_quo, o_rem;
    int         total = 0;
    int         bad = 0;
    exp_t       sb[$];
    div_08bit_restoring #(.DATA_W(8)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_signed   (i_signed),
        .i_num_a    (i_num_a),
        .i_num_b    (i_num_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_quo      (o_quo),
        .o_rem      (o_rem),
        .o_div_zero (o_div_zero),
        .o_busy     (o_busy)
    );
    always #5 i_clk = ~i_clk;
    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    function automatic exp_t model(input logic s, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   ia, ib;
        if (b == 8'd0) begin
            e.q = 8'hFF;
            e.r = a;
            e.z = 1'b1;
            return e;
        end
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        e.q = 8'(ia / ib);
        e.r = 8'(ia % ib);
        e.z = 1'b0;
        return e;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic s, input logic [7:0] a, input logic [7:0] b);
        i_signed = s;
        i_num_a  = a;
        i_num_b  = b;
        i_valid  = 1'b1;
        chk("ready_before_accept", 32'(o_ready), 32'd1);
        sb.push_back(model(s, a, b));
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask
    task automatic get_result(input string tag, input int lat, input bit rel);
        int   n = 0;
        exp_t e;
        while (!o_valid && n < 40) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_ready_low"}, 32'(o_ready), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_quo"}, 32'(o_quo), 32'(e.q));
            chk({tag, "_rem"}, 32'(o_rem), 32'(e.r));
            chk({tag, "_dz"}, 32'(o_div_zero), 32'(e.z));
        end
        if (rel) begin
            i_ready = 1'b1;
            @(posedge i_clk);
            #1 i_ready = 1'b0;
            chk({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
            chk({tag, "_ready_back"}, 32'(o_ready), 32'd1);
        end
    endtask
    initial begin
        logic [7:0] hq, hr;
        int         seen;
        exp_t       tmp;
        #12;
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_quo", 32'(o_quo), 32'd0);
        chk("rst_rem", 32'(o_rem), 32'd0);
        chk("rst_dz", 32'(o_div_zero), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        send(1'b0, 8'd200, 8'd7);
        chk("u200_7_busy", 32'(o_busy), 32'd1);
        get_result("u200_7", 9, 1'b1);
        send(1'b1, 8'h9C, 8'h07);
        get_result("sm100_7", 9, 1'b1);
        send(1'b1, 8'd100, 8'hF9);
        get_result("s100_m7", 9, 1'b1);
        send(1'b0, 8'h9C, 8'h07);
        get_result("u9c_7", 9, 1'b1);
        send(1'b0, 8'd37, 8'd0);
        get_result("dz37", 1, 1'b1);
        send(1'b1, 8'h80, 8'hFF);
        get_result("ovf", 9, 1'b1);
        chk("ovf_quo_const", 32'(o_quo), 32'h80);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            send(rs, ra, rb);
            get_result("rand", (rb == 8'd0) ? 1 : 9, 1'b1);
        end
        send(1'b0, 8'd200, 8'd7);
        get_result("bp1", 9, 1'b0);
        hq = o_quo;
        hr = o_rem;
        i_signed = 1'b0;
        i_num_a  = 8'd50;
        i_num_b  = 8'd3;
        i_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            chk("bp_hold_valid", 32'(o_valid), 32'd1);
            chk("bp_hold_ready", 32'(o_ready), 32'd0);
            chk("bp_hold_quo", 32'(o_quo), 32'(hq));
            chk("bp_hold_rem", 32'(o_rem), 32'(hr));
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_ready = 1'b0;
        chk("bp_release_valid", 32'(o_valid), 32'd0);
        chk("bp_release_ready", 32'(o_ready), 32'd1);
        sb.push_back(model(1'b0, 8'd50, 8'd3));
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        chk("bp_second_accepted", 32'(o_busy), 32'd1);
        get_result("bp2", 9, 1'b1);
        send(1'b1, 8'h9C, 8'h07);
        repeat (3) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_ready", 32'(o_ready), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_quo", 32'(o_quo), 32'd0);
        chk("abort_rem", 32'(o_rem), 32'd0);
        tmp = sb.pop_back();
        @(negedge i_clk) i_rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge i_clk);
            #1;
            if (o_valid || o_busy) seen++;
        end
        chk("abort_no_stale", 32'(seen), 32'd0);
        send(1'b0, 8'd255, 8'd16);
        get_result("after_abort", 9, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
